// File: rtl/hazard_flush_controller.sv
// Pipeline sequencer: load-use bubble insertion, wrong-path squash after taken
// control transfers, power-up/init drain, and saturating stall/flush statistics.
`timescale 1ns/1ps
module hazard_flush_controller #(
  parameter int INIT_CYCLES       = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [2:0]       id_r1Address,
  input  logic [2:0]       id_r2Address,
  input  logic             id_useR1,
  input  logic             id_useR2,
  input  logic             id_branchTaken,
  input  logic [2:0]       id_ex_dest,
  input  logic             id_ex_regWrite,
  input  logic             id_ex_regWriteDataSel,
  output logic             pcEnb,
  output logic             ifIdEnb,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic             busy,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int MAX_A  = (INIT_CYCLES > LOAD_STALL_CYCLES) ? INIT_CYCLES : LOAD_STALL_CYCLES;
  localparam int MAX_C  = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
  localparam int CTR_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CTR_W-1:0] INIT_LOAD  = CTR_W'(INIT_CYCLES - 1);
  localparam logic [CTR_W-1:0] STALL_LOAD = CTR_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CTR_W-1:0] FLUSH_LOAD = CTR_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc, flush_inc;
  logic             hz;

  // Dest 0 is a real register, so no zero-register exemption.
  assign hz = id_ex_regWrite & id_ex_regWriteDataSel &
              ((id_useR1 & (id_ex_dest == id_r1Address)) |
               (id_useR2 & (id_ex_dest == id_r2Address)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcEnb      = 1'b1;
    ifIdEnb    = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    busy       = 1'b1;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    unique case (state_q)
      S_INIT: begin
        pcEnb      = 1'b0;
        ifIdEnb    = 1'b0;
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CTR_W'(1);
      end

      S_RUN: begin
        busy = 1'b0;
        if (hz) begin
          pcEnb      = 1'b0;
          ifIdEnb    = 1'b0;
          idExBubble = 1'b1;
          stall_inc  = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = S_STALL;
            cnt_d   = STALL_LOAD;
          end
        end else if (id_branchTaken) begin
          ifIdFlush = 1'b1;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
      end

      S_STALL: begin
        pcEnb      = 1'b0;
        ifIdEnb    = 1'b0;
        idExBubble = 1'b1;
        stall_inc  = 1'b1;
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CTR_W'(1);
      end

      S_FLUSH: begin
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
        flush_inc  = 1'b1;
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CTR_W'(1);
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = INIT_LOAD;
      end
    endcase

    // init restarts the drain from any state; this cycle's bubble/squash still counts.
    if (init) begin
      state_d = S_INIT;
      cnt_d   = INIT_LOAD;
    end

    stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= INIT_LOAD;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stallCount = stall_q;
  assign flushCount = flush_q;

endmodule
